// File: rtl/axi_lite_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_pkg
// Shared types for the AXI-Lite subordinate slice.
//   axi_resp_t : AXI response encoding carried on bresp/rresp
//   w_state_t  : write-channel FSM state (also exported on a debug port)
//   r_state_t  : read-channel FSM state (also exported on a debug port)
//   idx_width  : width of a register index for a given register count
// -----------------------------------------------------------------------------
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_resp_t;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_ADDR_OK = 2'd1,
        W_DATA_OK = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    // A single-entry file still needs a one-bit index.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// -----------------------------------------------------------------------------
// axi_lite_regfile
// Register array behind the AXI-Lite subordinate: one synchronous write port,
// one asynchronous read port. All entries clear on reset.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_we             write enable (caller guarantees i_waddr is in range)
//   i_waddr/i_wdata  write index / data
//   i_raddr          read index (caller masks out-of-range reads)
//   o_rdata          combinational read data
// -----------------------------------------------------------------------------
module axi_lite_regfile
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int IDX_W      = idx_width(NUM_REGS)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_we,
    input  logic [IDX_W-1:0]      i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [IDX_W-1:0]      i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [NUM_REGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read before the clock edge: a read captured on the same edge as a write
    // to the same entry sees the old contents.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_lite_subordinate.sv
// -----------------------------------------------------------------------------
// axi_lite_subordinate
// AXI-Lite subordinate exposing NUM_REGS words of DATA_WIDTH bits. The address
// is used directly as the word index. Independent write and read FSMs run
// concurrently; one write and one read may be outstanding at a time.
//
// Handshake rule on every channel: a transfer happens on the rising edge where
// valid && ready are both high; the source holds payload stable while valid is
// high and ready is low; this block never waits on the opposite party's
// valid before raising its own ready.
//
// Build option: define AXI_LITE_SUB_SLVERR_EN to answer out-of-range accesses
// with SLVERR; otherwise they answer OKAY. Either way such writes are dropped
// and such reads return zero.
//
// Ports:
//   s_axi_clk, s_axi_resetn       clock, asynchronous active-low reset
//   s_axi_aw*  / s_axi_w*         write address / write data (wlast ignored)
//   s_axi_b*                      write response
//   s_axi_ar*  / s_axi_r*         read address / read data (rlast tied high)
//   o_dbg_w_state, o_dbg_r_state  current FSM states for observation
// -----------------------------------------------------------------------------
module axi_lite_subordinate
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 16
) (
    input  logic                  s_axi_clk,
    input  logic                  s_axi_resetn,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic                  s_axi_wvalid,
    input  logic                  s_axi_wlast,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    output logic                  s_axi_rlast,
    input  logic                  s_axi_rready,
    output w_state_t              o_dbg_w_state,
    output r_state_t              o_dbg_r_state
);

    localparam int IDX_W = idx_width(NUM_REGS);
    localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH + 1)'(NUM_REGS);

`ifdef AXI_LITE_SUB_SLVERR_EN
    localparam axi_resp_t LP_ERR_RESP = SLVERR;
`else
    localparam axi_resp_t LP_ERR_RESP = OKAY;
`endif

    // wlast carries no meaning for single-beat AXI-Lite transfers.
    logic w_unused;
    assign w_unused = s_axi_wlast;

    // Held low through reset and raised on the first edge afterwards, so all
    // ready outputs stay low while reset is asserted.
    logic r_alive;

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) r_alive <= 1'b0;
        else               r_alive <= 1'b1;
    end

    // ------------------------------------------------------------ write path
    w_state_t                r_wstate, w_wnext;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    axi_resp_t               r_bresp;

    logic                    w_aw_hs, w_w_hs, w_b_hs;
    logic                    w_commit;
    logic [ADDR_WIDTH-1:0]   w_cm_addr;
    logic [DATA_WIDTH-1:0]   w_cm_data;
    logic                    w_cm_in_range;

    assign s_axi_awready = r_alive && (r_wstate == W_IDLE || r_wstate == W_DATA_OK);
    assign s_axi_wready  = r_alive && (r_wstate == W_IDLE || r_wstate == W_ADDR_OK);
    assign s_axi_bvalid  = (r_wstate == W_RESP);
    assign s_axi_bresp   = r_bresp;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid  && s_axi_wready;
    assign w_b_hs  = s_axi_bvalid  && s_axi_bready;

    // The commit edge is the one completing the second of the AW/W handshakes;
    // whichever half arrived earlier comes from its latch, the other live.
    always_comb begin
        w_wnext   = r_wstate;
        w_commit  = 1'b0;
        w_cm_addr = s_axi_awaddr;
        w_cm_data = s_axi_wdata;
        case (r_wstate)
            W_IDLE: begin
                if (w_aw_hs && w_w_hs) begin
                    w_commit = 1'b1;
                    w_wnext  = W_RESP;
                end else if (w_aw_hs) begin
                    w_wnext = W_ADDR_OK;
                end else if (w_w_hs) begin
                    w_wnext = W_DATA_OK;
                end
            end
            W_ADDR_OK: begin
                if (w_w_hs) begin
                    w_commit  = 1'b1;
                    w_cm_addr = r_awaddr;
                    w_wnext   = W_RESP;
                end
            end
            W_DATA_OK: begin
                if (w_aw_hs) begin
                    w_commit  = 1'b1;
                    w_cm_data = r_wdata;
                    w_wnext   = W_RESP;
                end
            end
            W_RESP: begin
                if (w_b_hs) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    assign w_cm_in_range = ({1'b0, w_cm_addr} < LP_NUM_REGS);

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_wstate <= W_IDLE;
            r_awaddr <= '0;
            r_wdata  <= '0;
            r_bresp  <= OKAY;
        end else begin
            r_wstate <= w_wnext;
            if (w_aw_hs) r_awaddr <= s_axi_awaddr;
            if (w_w_hs)  r_wdata  <= s_axi_wdata;
            if (w_commit) r_bresp <= w_cm_in_range ? OKAY : LP_ERR_RESP;
        end
    end

    // ------------------------------------------------------------- read path
    r_state_t                r_rstate, w_rnext;
    logic [DATA_WIDTH-1:0]   r_rdata;
    axi_resp_t               r_rresp;
    logic                    w_ar_hs;
    logic                    w_ar_in_range;
    logic [DATA_WIDTH-1:0]   w_rd_word;

    assign s_axi_arready = r_alive && (r_rstate == R_IDLE);
    assign s_axi_rvalid  = (r_rstate == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = 1'b1;

    assign w_ar_hs       = s_axi_arvalid && s_axi_arready;
    assign w_ar_in_range = ({1'b0, s_axi_araddr} < LP_NUM_REGS);

    always_comb begin
        w_rnext = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rnext = R_DATA;
            R_DATA:  if (s_axi_rready) w_rnext = R_IDLE;
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_clk or negedge s_axi_resetn) begin
        if (!s_axi_resetn) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
            r_rresp  <= OKAY;
        end else begin
            r_rstate <= w_rnext;
            if (w_ar_hs) begin
                r_rdata <= w_ar_in_range ? w_rd_word : '0;
                r_rresp <= w_ar_in_range ? OKAY : LP_ERR_RESP;
            end
        end
    end

    assign o_dbg_w_state = r_wstate;
    assign o_dbg_r_state = r_rstate;

    // --------------------------------------------------------- register file
    axi_lite_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .i_clk   (s_axi_clk),
        .i_rst_n (s_axi_resetn),
        .i_we    (w_commit && w_cm_in_range),
        .i_waddr (w_cm_addr[IDX_W-1:0]),
        .i_wdata (w_cm_data),
        .i_raddr (s_axi_araddr[IDX_W-1:0]),
        .o_rdata (w_rd_word)
    );

endmodule
